// File: rtl/pb_conditioner.sv
// Pushbutton front end: per-button 2-flop sync, debounce FSM, press strobe,
// debounced level and fixed-rate auto-repeat while held.

module pb_lane #(
    parameter int CNT_W         = 25,
    parameter int DB_CYCLES     = 250000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pb_n,
    output logic o_pulse,
    output logic o_level
);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        REPEAT   = 3'd3,
        REL_DB   = 3'd4
    } state_t;

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             r_level;

    // Synchronizer resets to the released level so reset exit never looks like a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_pb_n;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_s2) begin
                        r_state <= PRESS_DB;
                        r_cnt   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (r_s2) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_pulse <= 1'b1;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (r_s2) begin
                        r_state <= REL_DB;
                        r_cnt   <= '0;
                    end else if ((REPEAT_EN != 0) && (r_cnt == RD_LAST)) begin
                        r_state <= REPEAT;
                        r_cnt   <= '0;
                        r_pulse <= 1'b1;
                    end else if (r_cnt != CNT_SAT) begin
                        // Without auto-repeat the hold time just parks at full scale.
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (r_s2) begin
                        r_state <= REL_DB;
                        r_cnt   <= '0;
                    end else if (r_cnt == RP_LAST) begin
                        r_cnt   <= '0;
                        r_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                REL_DB: begin
                    if (!r_s2) begin
                        // Release bounce: back to held, repeat delay starts over.
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_pulse = r_pulse;
    assign o_level = r_level;
endmodule

module pb_conditioner #(
    parameter int NUM_PB        = 4,
    parameter int CNT_W         = 25,
    parameter int DB_CYCLES     = 250000,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic              CLK_50,
    input  logic              reset,
    input  logic [NUM_PB-1:0] pb_n,
    output logic [NUM_PB-1:0] pb_pulse,
    output logic [NUM_PB-1:0] pb_level
);
    localparam int MAX_AB  = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam longint unsigned CNT_CAP = (64'd1 << CNT_W) - 64'd1;

    generate
        if (64'(MAX_CNT) > CNT_CAP) begin : g_cnt_w_chk
            $error("pb_conditioner: CNT_W too narrow for debounce/repeat counts");
        end
        if ((DB_CYCLES < 2) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_param_chk
            $error("pb_conditioner: timing parameters out of range");
        end
    endgenerate

    pb_lane #(
        .CNT_W         (CNT_W),
        .DB_CYCLES     (DB_CYCLES),
        .REPEAT_EN     (REPEAT_EN),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_lane [NUM_PB-1:0] (
        .i_clk   (CLK_50),
        .i_rst_n (reset),
        .i_pb_n  (pb_n),
        .o_pulse (pb_pulse),
        .o_level (pb_level)
    );
endmodule

// File: tb/tb_pb_conditioner.sv
// Bench for pb_conditioner: a repeat and a non-repeat instance share stimulus and
// are compared every cycle against a run-length model, plus directed scenarios.

module tb_pb_conditioner;
    localparam int NPB = 4;
    localparam int DB  = 8;
    localparam int RD  = 40;
    localparam int RP  = 10;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [NPB-1:0] pb_n  = '1;
    logic [NPB-1:0] pulse_r, level_r, pulse_n, level_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pb_conditioner #(.NUM_PB(NPB), .CNT_W(8), .DB_CYCLES(DB), .REPEAT_EN(1),
                     .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_rep (
        .CLK_50(clk), .reset(rst_n), .pb_n(pb_n), .pb_pulse(pulse_r), .pb_level(level_r));

    pb_conditioner #(.NUM_PB(NPB), .CNT_W(8), .DB_CYCLES(DB), .REPEAT_EN(0),
                     .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_norep (
        .CLK_50(clk), .reset(rst_n), .pb_n(pb_n), .pb_pulse(pulse_n), .pb_level(level_n));

    // Model index 0 = auto-repeat instance, 1 = single-pulse instance.
    bit ms1 [2][NPB];
    bit ms2 [2][NPB];
    bit mlv [2][NPB];
    bit mpl [2][NPB];
    int lo  [2][NPB];
    int hi  [2][NPB];
    int age [2][NPB];

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < NPB; b++) begin
                ms1[m][b] = 1'b1; ms2[m][b] = 1'b1;
                mlv[m][b] = 1'b0; mpl[m][b] = 1'b0;
                lo[m][b] = 0; hi[m][b] = 0; age[m][b] = 0;
            end
    endtask

    // Accept after DB+1 consecutive synchronized-low samples, release after DB+1 highs;
    // repeats are scheduled by time since the most recent start of a continuous hold.
    task automatic model_step();
        bit pressed;
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < NPB; b++) begin
                pressed   = !ms2[m][b];
                ms2[m][b] = ms1[m][b];
                ms1[m][b] = pb_n[b];
                mpl[m][b] = 1'b0;
                if (pressed) begin lo[m][b]++; hi[m][b] = 0; end
                else begin hi[m][b]++; lo[m][b] = 0; end
                if (!mlv[m][b]) begin
                    if (lo[m][b] == DB + 1) begin
                        mlv[m][b] = 1'b1; mpl[m][b] = 1'b1; age[m][b] = 0;
                    end
                end else if (!pressed) begin
                    if (hi[m][b] == DB + 1) mlv[m][b] = 1'b0;
                end else if (lo[m][b] == 1) begin
                    age[m][b] = 0;
                end else begin
                    age[m][b]++;
                    if (m == 0 && (age[m][b] == RD ||
                                   (age[m][b] > RD && (age[m][b] - RD) % RP == 0)))
                        mpl[m][b] = 1'b1;
                end
            end
    endtask

    function automatic logic [NPB-1:0] mvec(int m, bit lvl);
        logic [NPB-1:0] v;
        for (int b = 0; b < NPB; b++) v[b] = lvl ? mlv[m][b] : mpl[m][b];
        return v;
    endfunction

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic chk_model();
        checks++;
        if ({pulse_r, level_r} !== {mvec(0, 1'b0), mvec(0, 1'b1)}) begin
            errors++;
            $display("FAIL model_rep @%0t: pulse/level %b/%b required %b/%b",
                     $time, pulse_r, level_r, mvec(0, 1'b0), mvec(0, 1'b1));
        end
        checks++;
        if ({pulse_n, level_n} !== {mvec(1, 1'b0), mvec(1, 1'b1)}) begin
            errors++;
            $display("FAIL model_norep @%0t: pulse/level %b/%b required %b/%b",
                     $time, pulse_n, level_n, mvec(1, 1'b0), mvec(1, 1'b1));
        end
    endtask

    // One clock: the model sees exactly what the DUT samples, outputs checked on negedge.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
        chk_model();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    typedef struct {
        int btn;
        int low_len;
        int np_rep;
        int np_norep;
        int first_t;
        int fall_t;
    } vec_t;

    vec_t vt[5];
    int np_r, np_n, first, fall, other, hits, any;
    logic prev_l;

    initial begin
        vt[0] = '{2, 60,  3, 1, 10,  70};
        vt[1] = '{1,  5,  0, 0, -1,  -1};
        vt[2] = '{3, 100, 7, 1, 10, 110};
        vt[3] = '{0,  9,  1, 1, 10,  19};
        vt[4] = '{0,  8,  0, 0, -1,  -1};

        model_reset();
        @(negedge clk);
        chk("reset_async_out", int'({pulse_r, level_r, pulse_n, level_n}), 0);
        idle(3);
        rst_n = 1'b1;
        idle(5);

        for (int i = 0; i < 5; i++) begin
            idle(30);
            pb_n[vt[i].btn] = 1'b0;
            np_r = 0; np_n = 0; first = -1; fall = -1; other = 0; prev_l = 1'b0;
            for (int k = 0; k < vt[i].low_len + DB + 20; k++) begin
                cyc();
                if (pulse_r[vt[i].btn]) begin np_r++; if (first < 0) first = k; end
                if (pulse_n[vt[i].btn]) np_n++;
                if (prev_l && !level_r[vt[i].btn] && fall < 0) fall = k;
                prev_l = level_r[vt[i].btn];
                for (int b = 0; b < NPB; b++)
                    if (b != vt[i].btn && (pulse_r[b] || level_r[b])) other++;
                if (k == vt[i].low_len - 1) pb_n[vt[i].btn] = 1'b1;
            end
            chk($sformatf("vec%0d_pulses_rep", i), np_r, vt[i].np_rep);
            chk($sformatf("vec%0d_pulses_norep", i), np_n, vt[i].np_norep);
            chk($sformatf("vec%0d_first_t", i), first, vt[i].first_t);
            chk($sformatf("vec%0d_level_fall_t", i), fall, vt[i].fall_t);
            chk($sformatf("vec%0d_other_bits", i), other, 0);
        end

        // Bouncy press: 3-cycle glitches must be rejected, then one clean accept.
        idle(30);
        np_r = 0; np_n = 0;
        for (int ph = 0; ph < 9; ph++) begin
            pb_n[0] = (ph < 8) ? ph[0] : 1'b0;
            for (int k = 0; k < ((ph < 8) ? 3 : 30); k++) begin
                cyc();
                if (pulse_r[0]) np_r++;
                if (pulse_n[0]) np_n++;
            end
        end
        pb_n[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (pulse_r[0]) np_r++;
            if (pulse_n[0]) np_n++;
        end
        chk("bounce_pulses_rep", np_r, 1);
        chk("bounce_pulses_norep", np_n, 1);

        // Two buttons on the same edge pulse together, once.
        idle(30);
        pb_n = 4'b0110;
        hits = 0; any = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (pulse_r == 4'b1001) hits++;
            if (pulse_r != 4'b0000) any++;
        end
        pb_n = '1;
        chk("simul_same_cycle", hits, 1);
        chk("simul_pulse_cycles", any, 1);
        idle(20);

        // Reset while held: outputs clear at once, then exactly one re-accept.
        pb_n[1] = 1'b0;
        idle(21);
        chk("pre_reset_level", int'(level_r[1]), 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset_mid_async", int'({pulse_r, level_r, pulse_n, level_n}), 0);
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        first = -1; np_r = 0; np_n = 0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (pulse_r[1]) begin np_r++; if (first < 0) first = k; end
            if (pulse_n[1]) np_n++;
        end
        chk("reset_reaccept_edge", first, DB + 3);
        chk("reset_reaccept_rep", np_r, 1);
        chk("reset_reaccept_norep", np_n, 1);
        pb_n = '1;
        idle(20);

        // Random held patterns with occasional asynchronous resets.
        for (int seg = 0; seg < 150; seg++) begin
            pb_n = NPB'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                model_reset();
                idle(2);
                rst_n = 1'b1;
            end
            idle($urandom_range(1, 60));
        end
        pb_n = '1;
        idle(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
